// File: rtl/fir_decim_out_if.sv
// Sample handshake bundle for the FIR decimator output stage:
// input sample qualifier/data and the valid/ready output side.
interface fir_decim_out_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/fir_decim_out.sv
// FIR output stage: decimate, round/shift/saturate, and buffer
// samples in a show-ahead FIFO with sticky saturation/overflow flags.
module fir_decim_out #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fir_decim_out_if.slave bus,
    input  logic           clr_flags,
    output logic           sat_flag,
    output logic           ovf_flag
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

    localparam logic signed [IN_W:0] RND =
        (IN_W + 1)'(1 << (SHIFT - 1));
    localparam logic signed [IN_W:0] QMAX =
        (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] QMIN =
        (IN_W + 1)'(-(1 << (OUT_W - 1)));

    logic [PW-1:0]           phase;
    logic                    keep;
    logic signed [IN_W:0]    sum;
    logic signed [IN_W:0]    q;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_ev;

    logic                    st_valid;
    logic signed [OUT_W-1:0] st_data;

    logic signed [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    wr_en;
    logic                    drop;

    always_comb begin
        keep    = bus.in_valid && (phase == '0);
        sum     = {bus.in_data[IN_W-1], bus.in_data} + RND;
        q       = sum >>> SHIFT;
        sat_val = q[OUT_W-1:0];
        sat_ev  = 1'b0;
        if (q > QMAX) begin
            sat_val = QMAX[OUT_W-1:0];
            sat_ev  = keep;
        end else if (q < QMIN) begin
            sat_val = QMIN[OUT_W-1:0];
            sat_ev  = keep;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (bus.in_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= 1'b0;
            st_data  <= '0;
        end else begin
            st_valid <= keep;
            if (keep) begin
                st_data <= sat_val;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves the same cycle.
    always_comb begin
        empty = (count == '0);
        full  = (count == FULL);
        pop   = !empty && bus.out_ready;
        wr_en = st_valid && (!full || pop);
        drop  = st_valid && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (sat_ev) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag <= 1'b0;
            end
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];
endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
Output stage placed directly downstream of the parallel FIR low-pass in the AM demodulator chain. It takes the full-precision 16-bit signed filter output on every valid clock and decimates it by DECIM. Each kept sample is rounded, shifted and saturated to OUT_W bits, then buffered in a small FIFO. The FIFO presents the samples to the next consumer (audio DAC/UART framer) over a valid/ready handshake.

Parameters:
IN_W, 16, width of signed input sample (FIR y)
OUT_W, 8, width of signed output sample
SHIFT, 7, arithmetic right-shift applied after rounding (>=1)
DECIM, 4, decimation ratio (>=1; 1 = keep every sample)
DEPTH, 4, FIFO depth in entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  in_data qualifier; tie high when fed by the FIR every clock
in_data  in  IN_W  signed filter output
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  OUT_W  signed FIFO head sample
sat_flag  out  1  sticky: a kept sample was saturated
ovf_flag  out  1  sticky: a kept sample was dropped on FIFO full
clr_flags  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async, rst=1): phase counter=0, stage register invalid, FIFO empty (pointers and count 0), out_valid=0, out_data=0, sat_flag=0, ovf_flag=0.
- Decimation: the phase counter advances only on in_valid=1 and counts 0..DECIM-1, wrapping to 0. A sample is kept when in_valid=1 and phase==0. The first valid sample after reset is therefore kept; the next DECIM-1 valid samples are discarded. in_valid=0 cycles do not advance the counter.
- Arithmetic (stage register, 1 cycle):
  - sum = sign-extend(in_data, IN_W+1) + 2^(SHIFT-1) (round half up).
  - q = sum >>> SHIFT (arithmetic).
  - If q > 2^(OUT_W-1)-1, clamp to 2^(OUT_W-1)-1. If q < -2^(OUT_W-1), clamp to -2^(OUT_W-1). Either clamp sets sat_flag.
  - The stage register holds the result plus a valid bit.
- FIFO: show-ahead (no fall-through).
  - push = stage valid; pop = out_valid & out_ready.
  - out_data = mem[rd_ptr] when count!=0, else 0; out_valid = (count!=0).
  - Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
- Latency: a kept sample presented in cycle n is loaded into the stage at edge n. It is written to the FIFO at edge n+1 and is visible on out_data/out_valid in cycle n+2 if the FIFO was empty. Throughput is 1 sample/clock when DECIM=1 and out_ready=1.
- Boundary conditions:
  - Full, push, no pop: sample dropped, FIFO unchanged, ovf_flag set.
  - Full, push and pop in the same cycle: both happen, count stays DEPTH, no drop.
  - Empty, push and pop: pop ignored (out_valid=0), push happens.
  - out_ready=1 while out_valid=0: no effect.
  - clr_flags in the same cycle as a set event: the set wins (flag=1 after the edge).
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: all state clears immediately, buffered samples are lost, and the phase restarts at 0.

Test Plan:
1. DECIM=4, SHIFT=7, out_ready=1, in_valid=1 with in_data = 64, 1000, 1000, 1000, -64, ... -> out_data 1 then 0. The first appears 2 cycles after the 64 input. The 1000 samples are never output. sat_flag=0.
2. Saturation: kept inputs 32767 and -32768 -> out_data 127 and -128, sat_flag=1. Pulse clr_flags -> sat_flag=0. clr_flags coinciding with a new saturating sample -> sat_flag stays 1.
3. Gapped in_valid (1,0,0,1,1,0,1,1, kept sample values 128, 256) -> outputs 1, 2. Exactly one output per 4 valid samples regardless of the gaps.
4. Backpressure: DECIM=1, out_ready=0, 6 kept inputs 128..768 step 128 -> FIFO holds 1,2,3,4 and ovf_flag=1. Raise out_ready -> drains 1,2,3,4 in order, and out_data is held stable while stalled.
5. Full with simultaneous push/pop: FIFO full, out_ready=1, input continues -> no drops, ovf_flag stays 0, count stays 4.
6. Assert rst for 1 cycle mid-stream with 3 entries buffered -> out_valid=0, out_data=0, both flags 0 asynchronously. The next valid input is kept (phase 0).
